csr_exec_pipe: RTL and testbench



---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_exec_pipe_if.sv | 49 ++++
 rtl/csr_alu.sv | 50 +++++
 rtl/csr_exec_pipe.sv | 92 +++++++++
 tb/tb_csr_exec_pipe.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR execute path.
// Zicsr funct3 encodings and the MEM/WB register bundles.
package csr_pkg;

  localparam int XLEN       = 32;
  localparam int CSR_ADDR_W = 12;
  localparam int CSR_IDX_W  = 5;
  localparam int GPR_IDX_W  = 5;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  typedef struct packed {
    logic                  wen;
    logic [CSR_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic                  gpr_wen;
    logic [GPR_IDX_W-1:0]  rd;
    logic [XLEN-1:0]       old;
  } mem_t;

  typedef struct packed {
    logic                  wen;
    logic [CSR_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_t;

  // The CSR file only decodes the low index bits.
  function automatic logic idx_match(
    input logic [CSR_ADDR_W-1:0] a,
    input logic [CSR_ADDR_W-1:0] b
  );
    return a[CSR_IDX_W-1:0] == b[CSR_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/csr_exec_pipe_if.sv
// EX-stage request, CSR file ports and GPR writeback bundle.
// slave is the execute path, master is the surrounding core.
interface csr_exec_pipe_if;
  import csr_pkg::*;

  logic                  bubble;
  logic                  flush;
  logic                  csr_valid_ex;
  logic [2:0]            funct3_ex;
  logic [CSR_ADDR_W-1:0] csr_addr_ex;
  logic [4:0]            rs1_idx_ex;
  logic [XLEN-1:0]       rs1_data_ex;
  logic [GPR_IDX_W-1:0]  rd_ex;
  logic [XLEN-1:0]       csr_rdata;

  logic                  csr_read_en;
  logic [CSR_ADDR_W-1:0] csr_read_addr;
  logic                  csr_write_en;
  logic [CSR_ADDR_W-1:0] csr_wb_addr;
  logic [XLEN-1:0]       csr_wb_data;
  logic                  gpr_wen_mem;
  logic [GPR_IDX_W-1:0]  gpr_rd_mem;
  logic [XLEN-1:0]       gpr_val_mem;

  modport slave (
    input  bubble, flush, csr_valid_ex,
    input  funct3_ex, csr_addr_ex,
    input  rs1_idx_ex, rs1_data_ex,
    input  rd_ex, csr_rdata,
    output csr_read_en, csr_read_addr,
    output csr_write_en, csr_wb_addr,
    output csr_wb_data,
    output gpr_wen_mem, gpr_rd_mem,
    output gpr_val_mem
  );

  modport master (
    output bubble, flush, csr_valid_ex,
    output funct3_ex, csr_addr_ex,
    output rs1_idx_ex, rs1_data_ex,
    output rd_ex, csr_rdata,
    input  csr_read_en, csr_read_addr,
    input  csr_write_en, csr_wb_addr,
    input  csr_wb_data,
    input  gpr_wen_mem, gpr_rd_mem,
    input  gpr_val_mem
  );

endinterface

// File: rtl/csr_alu.sv
// Read-modify-write datapath for one Zicsr operation.
// Also decides whether the CSR is read and/or written.
module csr_alu
  import csr_pkg::*;
(
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  input  logic            rd_zero_i,
  input  logic            rs1_zero_i,
  output logic [XLEN-1:0] new_o,
  output logic            wen_o,
  output logic            ren_o
);

  logic is_rw;
  logic is_rs;
  logic is_rc;

  // Low two bits pick the op; 00 is not a CSR op.
  assign is_rw = valid_i && op_i[1:0] == CSRRW[1:0];
  assign is_rs = valid_i && op_i[1:0] == CSRRS[1:0];
  assign is_rc = valid_i && op_i[1:0] == CSRRC[1:0];

  always_comb begin
    new_o = '0;
    wen_o = 1'b0;
    ren_o = 1'b0;
    unique case (1'b1)
      is_rw: begin
        new_o = src_i;
        wen_o = 1'b1;
        ren_o = !rd_zero_i;
      end
      is_rs: begin
        new_o = old_i | src_i;
        wen_o = !rs1_zero_i;
        ren_o = 1'b1;
      end
      is_rc: begin
        new_o = old_i & ~src_i;
        wen_o = !rs1_zero_i;
        ren_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_exec_pipe.sv
// CSR execute path: forwarding, RMW in EX, MEM/WB registers.
// The CSR write is issued from WB; the old value leaves from MEM.
module csr_exec_pipe
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  csr_exec_pipe_if.slave  bus
);

  mem_t            mem_q, mem_d;
  wb_t             wb_q, wb_d;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old;
  logic [XLEN-1:0] new_val;
  logic            alu_wen;
  logic            alu_ren;
  logic            mem_hit;
  logic            wb_hit;

  assign src = bus.funct3_ex[2]
             ? {27'b0, bus.rs1_idx_ex}
             : bus.rs1_data_ex;

  assign mem_hit = mem_q.wen &&
    idx_match(mem_q.addr, bus.csr_addr_ex);
  assign wb_hit = wb_q.wen &&
    idx_match(wb_q.addr, bus.csr_addr_ex);

  // Youngest in-flight write wins.
  always_comb begin
    old = bus.csr_rdata;
    if (mem_hit)
      old = mem_q.data;
    else if (wb_hit)
      old = wb_q.data;
  end

  csr_alu u_alu (
    .valid_i    (bus.csr_valid_ex),
    .op_i       (bus.funct3_ex),
    .old_i      (old),
    .src_i      (src),
    .rd_zero_i  (bus.rd_ex == '0),
    .rs1_zero_i (bus.rs1_idx_ex == '0),
    .new_o      (new_val),
    .wen_o      (alu_wen),
    .ren_o      (alu_ren)
  );

  assign bus.csr_read_en   = alu_ren;
  assign bus.csr_read_addr = bus.csr_addr_ex;

  always_comb begin
    mem_d = '0;
    if (alu_ren || alu_wen) begin
      mem_d.wen     = alu_wen;
      mem_d.addr    = bus.csr_addr_ex;
      mem_d.data    = new_val;
      mem_d.gpr_wen = alu_ren;
      mem_d.rd      = bus.rd_ex;
      mem_d.old     = old;
    end
    if (bus.flush)
      mem_d = '0;
  end

  always_comb begin
    wb_d      = '0;
    wb_d.wen  = mem_q.wen;
    wb_d.addr = mem_q.addr;
    wb_d.data = mem_q.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.bubble) begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.csr_write_en = wb_q.wen;
  assign bus.csr_wb_addr  = wb_q.addr;
  assign bus.csr_wb_data  = wb_q.data;
  assign bus.gpr_wen_mem  = mem_q.gpr_wen;
  assign bus.gpr_rd_mem   = mem_q.rd;
  assign bus.gpr_val_mem  = mem_q.old;

endmodule

// File: tb/tb_csr_exec_pipe.sv
// Bench for csr_exec_pipe: directed cases then random ops,
// against a sequential architectural CSR model.
module tb_csr_exec_pipe;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  csr_exec_pipe_if bus ();

  csr_exec_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // CSR file: combinational read, commit on negedge.
  logic [31:0] csr_file [32] = '{default: 32'h0};
  int          commits = 0;

  assign bus.csr_rdata = csr_file[bus.csr_read_addr[4:0]];

  always @(negedge clk) begin
    if (bus.csr_write_en) begin
      csr_file[bus.csr_wb_addr[4:0]] <= bus.csr_wb_data;
      commits <= commits + 1;
    end
  end

  typedef struct {
    bit        ren;
    bit        gwen;
    bit [4:0]  rd;
    bit [31:0] gval;
    bit        wen;
    bit [11:0] waddr;
    bit [31:0] wdata;
  } exp_t;

  bit [31:0] arch [32];
  exp_t      prev;
  int        n_vec = 0;
  int        n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Sequential ISA semantics of one instruction.
  task automatic model(
    input  bit        valid,
    input  bit [2:0]  f3,
    input  bit [11:0] addr,
    input  bit [4:0]  idx,
    input  bit [31:0] data,
    input  bit [4:0]  rd,
    input  bit        commit,
    output exp_t      e
  );
    bit [31:0] src, o, nv;
    e = '{default: 0};
    if (!valid || f3[1:0] == 2'b00) return;
    src = f3[2] ? {27'b0, idx} : data;
    o   = arch[addr[4:0]];
    case (f3[1:0])
      2'b01: begin
        nv = src; e.wen = 1; e.ren = (rd != 0);
      end
      2'b10: begin
        nv = o | src; e.wen = (idx != 0); e.ren = 1;
      end
      default: begin
        nv = o & ~src; e.wen = (idx != 0); e.ren = 1;
      end
    endcase
    e.gwen  = e.ren;
    e.rd    = rd;
    e.gval  = o;
    e.waddr = addr;
    e.wdata = nv;
    if (commit && e.wen) arch[addr[4:0]] = nv;
  endtask

  task automatic drive(
    input bit        valid,
    input bit [2:0]  f3,
    input bit [11:0] addr,
    input bit [4:0]  idx,
    input bit [31:0] data,
    input bit [4:0]  rd,
    input bit        fl
  );
    bus.csr_valid_ex = valid;
    bus.funct3_ex    = f3;
    bus.csr_addr_ex  = addr;
    bus.rs1_idx_ex   = idx;
    bus.rs1_data_ex  = data;
    bus.rd_ex        = rd;
    bus.flush        = fl;
    bus.bubble       = 1'b0;
  endtask

  task automatic chk_wb(input string t, input exp_t p);
    chk({t, "_wen"}, bus.csr_write_en, p.wen);
    if (p.wen) begin
      chk({t, "_waddr"}, bus.csr_wb_addr, p.waddr);
      chk({t, "_wdata"}, bus.csr_wb_data, p.wdata);
    end
  endtask

  task automatic chk_mem(input string t, input exp_t c);
    chk({t, "_gwen"}, bus.gpr_wen_mem, c.gwen);
    if (c.gwen) begin
      chk({t, "_grd"}, bus.gpr_rd_mem, c.rd);
      chk({t, "_gval"}, bus.gpr_val_mem, c.gval);
    end
  endtask

  // One EX instruction, called at posedge+1.
  task automatic step(
    input string     t,
    input bit        valid,
    input bit [2:0]  f3,
    input bit [11:0] addr,
    input bit [4:0]  idx,
    input bit [31:0] data,
    input bit [4:0]  rd,
    input bit        fl
  );
    exp_t e;
    model(valid, f3, addr, idx, data, rd, !fl, e);
    drive(valid, f3, addr, idx, data, rd, fl);
    #1;
    chk({t, "_ren"}, bus.csr_read_en, e.ren);
    chk({t, "_raddr"}, bus.csr_read_addr, addr);
    @(posedge clk);
    #1;
    if (fl) e = '{default: 0};
    chk_mem(t, e);
    chk_wb(t, prev);
    prev = e;
  endtask

  task automatic nop(input string t);
    step(t, 0, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 0);
  endtask

  initial begin
    exp_t e;
    int   c0;
    prev = '{default: 0};
    foreach (arch[i]) arch[i] = '0;
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", bus.csr_write_en, 0);
    chk("rst_waddr", bus.csr_wb_addr, 0);
    chk("rst_wdata", bus.csr_wb_data, 0);
    chk("rst_gwen", bus.gpr_wen_mem, 0);
    chk("rst_grd", bus.gpr_rd_mem, 0);
    chk("rst_gval", bus.gpr_val_mem, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write: 0x1234 -> 0x005, old value 0
    step("w1", 1, CSRRW, 12'h005, 5'd1, 32'h1234, 5'd3, 0);
    chk("w1_gval0", bus.gpr_val_mem, 32'h0);
    nop("w1_n");
    chk("w1_fdata", bus.csr_wb_data, 32'h1234);
    nop("w1_n2");

    // Back-to-back set/clear at 0x10
    step("b0", 1, CSRRW, 12'h005, 5'd1, 32'h10, 5'd0, 0);
    nop("b0_n");
    nop("b0_n2");
    step("bs", 1, CSRRSI, 12'h005, 5'd3, 32'h0, 5'd8, 0);
    step("bc", 1, CSRRCI, 12'h005, 5'd1, 32'h0, 5'd9, 0);
    chk("bc_gval", bus.gpr_val_mem, 32'h13);
    chk("bs_wdata", bus.csr_wb_data, 32'h13);
    nop("bc_n");
    chk("bc_wdata", bus.csr_wb_data, 32'h12);
    nop("bc_n2");
    chk("bc_file", csr_file[5], 32'h12);

    // Distance-2 forwarding, RS with x0
    step("d2w", 1, CSRRW, 12'h007, 5'd2, 32'hAA, 5'd4, 0);
    nop("d2n");
    step("d2s", 1, CSRRS, 12'h007, 5'd0, 32'hFF, 5'd5, 0);
    chk("d2_gval", bus.gpr_val_mem, 32'hAA);
    nop("d2n2");
    chk("d2_nowr", bus.csr_write_en, 0);
    nop("d2n3");

    // Read suppress: RW with rd=0 still writes
    step("rs0", 1, CSRRW, 12'h008, 5'd7, 32'h5A5A, 5'd0, 0);
    nop("rs0_n");
    chk("rs0_wr", bus.csr_write_en, 1);
    nop("rs0_n2");

    // Bubble for 3 cycles with a write in MEM
    model(1, CSRRW, 12'h009, 5'd1, 32'hDEADBEEF, 5'd4, 1, e);
    drive(1, CSRRW, 12'h009, 5'd1, 32'hDEADBEEF, 5'd4, 0);
    @(posedge clk);
    #1;
    chk_mem("bub0", e);
    chk_wb("bub0", prev);
    c0 = commits;
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 0);
    bus.bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bub_hold_wen", bus.csr_write_en, 0);
      chk("bub_hold_gwen", bus.gpr_wen_mem, 1);
    end
    bus.bubble = 1'b0;
    @(posedge clk);
    #1;
    chk_wb("bub1", '{wen: 1, waddr: 12'h009,
      wdata: 32'hDEADBEEF, default: 0});
    prev = '{default: 0};
    nop("bub_n");
    nop("bub_n2");
    chk("bub_once", commits - c0, 1);

    // Flush of a CSRRW in EX
    step("fl", 1, CSRRW, 12'h00A, 5'd1, 32'h55, 5'd6, 1);
    nop("fl_n");
    nop("fl_n2");
    chk("fl_file", csr_file[10], 32'h0);

    // Async reset with a write in MEM
    drive(1, CSRRW, 12'h00B, 5'd1, 32'h77, 5'd7, 0);
    @(posedge clk);
    #1;
    chk("ar_gwen", bus.gpr_wen_mem, 1);
    c0 = commits;
    drive(0, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_gwen0", bus.gpr_wen_mem, 0);
    chk("ar_wen0", bus.csr_write_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev = '{default: 0};
    nop("ar_n");
    nop("ar_n2");
    nop("ar_n3");
    chk("ar_dropped", commits - c0, 0);

    // Random ops over aliasing addresses
    for (int i = 0; i < 300; i++) begin
      bit        v, fl;
      bit [2:0]  f3;
      bit [11:0] a;
      bit [4:0]  idx, rd;
      v   = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      f3  = 3'($urandom_range(0, 7));
      a   = {7'($urandom), 5'($urandom_range(0, 3))};
      idx = ($urandom_range(0, 3) == 0)
          ? 5'd0 : 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0)
          ? 5'd0 : 5'($urandom);
      step("rnd", v, f3, a, idx, $urandom, rd, fl);
    end
    nop("end_n");
    nop("end_n2");
    for (int i = 0; i < 32; i++)
      chk("final_file", csr_file[i], arch[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
